// File: rtl/regfile_mp_if.sv
// regfile_mp_if: issue/writeback bus of the multi-port register file.
interface regfile_mp_if #(
   parameter int ADDR_SIZE = 5,
   parameter int XLEN      = 64,
   parameter int NUM_READ  = 2,
   parameter int NUM_WRITE = 1
);
   logic [NUM_WRITE-1:0]                write_enable;
   logic [NUM_WRITE-1:0][ADDR_SIZE-1:0] write_addr;
   logic [NUM_WRITE-1:0][XLEN-1:0]      write_data;
   logic [NUM_READ-1:0]                 read_enable;
   logic [NUM_READ-1:0][ADDR_SIZE-1:0]  read_addr;
   logic [NUM_READ-1:0][XLEN-1:0]       read_data;
   logic [NUM_READ-1:0]                 read_busy;
   logic                                reserve_enable;
   logic [ADDR_SIZE-1:0]                reserve_addr;
   logic                                flush;
   logic [2**ADDR_SIZE-1:0]             busy_vec;
   modport master (
      output write_enable, write_addr, write_data, read_enable, read_addr,
             reserve_enable, reserve_addr, flush,
      input  read_data, read_busy, busy_vec
   );
   modport slave (
      input  write_enable, write_addr, write_data, read_enable, read_addr,
             reserve_enable, reserve_addr, flush,
      output read_data, read_busy, busy_vec
   );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with busy scoreboard, x0 hardwired to zero.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp #(
   parameter int ADDR_SIZE = 5,
   parameter int XLEN      = 64,
   parameter int NUM_READ  = 2,
   parameter int NUM_WRITE = 1
) (
   input logic          i_clk,
   input logic          i_rst_n,
   regfile_mp_if.slave  bus
);
   localparam int NUM_REGISTERS = 2**ADDR_SIZE;
   if (NUM_READ < 1 || NUM_READ > 4 || NUM_WRITE < 1 || NUM_WRITE > 2 || ADDR_SIZE < 1 || XLEN < 1) begin : g_bad_cfg
      $error("regfile_mp: parameter out of range");
   end
   logic [XLEN-1:0]          w_regs [NUM_REGISTERS];
   logic [NUM_REGISTERS-1:0] r_busy;
   logic [NUM_REGISTERS-1:0] w_busy_nxt;
   // flush beats reserve, reserve beats writeback clear
   always_comb begin
      w_busy_nxt = r_busy;
      for (int i = 0; i < NUM_WRITE; i++)
         if (bus.write_enable[i]) w_busy_nxt[bus.write_addr[i]] = 1'b0;
      if (bus.reserve_enable) w_busy_nxt[bus.reserve_addr] = 1'b1;
      if (bus.flush) w_busy_nxt = '0;
      w_busy_nxt[0] = 1'b0;
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_busy <= '0;
      else r_busy <= w_busy_nxt;
   assign bus.busy_vec = r_busy;
   for (genvar k = 0; k < NUM_REGISTERS; k++) begin : g_reg
      if (k == 0) begin : g_zero
         assign w_regs[k] = '0;
      end else begin : g_data
         logic            r_reg;
         logic [XLEN-1:0] r_val;
         logic            w_we;
         logic [XLEN-1:0] w_wd;
         // later port overrides earlier one on an address collision
         always_comb begin
            w_we = 1'b0;
            w_wd = r_val;
            for (int i = 0; i < NUM_WRITE; i++)
               if (bus.write_enable[i] && bus.write_addr[i] == ADDR_SIZE'(k)) begin
                  w_we = 1'b1;
                  w_wd = bus.write_data[i];
               end
         end
         always_ff @(posedge i_clk or negedge i_rst_n)
            if (!i_rst_n) r_val <= '0;
            else if (w_we) r_val <= w_wd;
         assign r_reg = 1'b0;
         assign w_regs[k] = r_val;
      end
   end
   for (genvar j = 0; j < NUM_READ; j++) begin : g_rd
      logic [XLEN-1:0] w_rd;
      logic            w_rb;
      logic            w_on;
      always_comb begin
         w_rd = w_regs[bus.read_addr[j]];
         w_rb = r_busy[bus.read_addr[j]];
`ifdef REGFILE_BYPASS_EN
         for (int i = 0; i < NUM_WRITE; i++)
            if (bus.write_enable[i] && bus.write_addr[i] == bus.read_addr[j]) begin
               w_rd = bus.write_data[i];
               w_rb = 1'b0;
            end
`else
         w_rb = w_rb;
`endif
      end
      assign w_on = i_rst_n && bus.read_enable[j] && bus.read_addr[j] != '0;
      assign bus.read_data[j] = w_on ? w_rd : '0;
      assign bus.read_busy[j] = w_on ? w_rb : 1'b0;
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (NUM_WRITE = 2).
module tb_regfile_mp;
   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   localparam logic [63:0] BIG = 64'hDEAD_BEEF_0000_0001;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   always #5 clk = ~clk;
   regfile_mp_if #(.ADDR_SIZE(5), .XLEN(64), .NUM_READ(2), .NUM_WRITE(2)) bus ();
   regfile_mp #(.ADDR_SIZE(5), .XLEN(64), .NUM_READ(2), .NUM_WRITE(2)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   initial begin
      rst_n = 1'b0;
      bus.write_enable = '0;
      bus.write_addr = '0;
      bus.write_data = '0;
      bus.read_enable = 2'b11;
      bus.read_addr = '0;
      bus.reserve_enable = 1'b0;
      bus.reserve_addr = '0;
      bus.flush = 1'b0;
      repeat (2) @(negedge clk);
      for (int a = 0; a < 32; a++) begin
         bus.read_addr[0] = 5'(a);
         bus.read_addr[1] = 5'(31 - a);
         #1;
         check("rst_rd0", bus.read_data[0], 64'd0);
         check("rst_rd1", bus.read_data[1], 64'd0);
      end
      check("rst_busy_vec", 64'(bus.busy_vec), 64'd0);
      bus.write_enable[0] = 1'b1;
      bus.write_addr[0] = 5'd5;
      bus.write_data[0] = 64'h55;
      bus.read_addr[0] = 5'd5;
      #1 check("rst_forced_rd", bus.read_data[0], 64'd0);
      bus.write_enable = '0;
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      bus.write_enable[0] = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      bus.write_enable = '0;
      rst_n = 1'b1;
      #1 check("rst_inflight_x5", bus.read_data[0], 64'd0);
      bus.write_enable[0] = 1'b1;
      bus.write_data[0] = BIG;
      #1 check("same_cycle_x5", bus.read_data[0], BYP ? BIG : 64'd0);
      @(negedge clk) bus.write_enable = '0;
      #1 check("next_cycle_x5", bus.read_data[0], BIG);
      bus.write_enable[0] = 1'b1;
      bus.write_addr[0] = 5'd0;
      bus.write_data[0] = 64'h1234;
      bus.read_addr[0] = 5'd0;
      @(negedge clk) bus.write_enable = '0;
      #1 check("x0_read", bus.read_data[0], 64'd0);
      bus.reserve_enable = 1'b1;
      bus.reserve_addr = 5'd0;
      @(negedge clk) bus.reserve_enable = 1'b0;
      #1 check("x0_reserve", 64'(bus.busy_vec), 64'd0);
      bus.write_enable = 2'b11;
      bus.write_addr[0] = 5'd7;
      bus.write_addr[1] = 5'd7;
      bus.write_data[0] = 64'h11;
      bus.write_data[1] = 64'h22;
      bus.read_addr[0] = 5'd7;
      bus.read_addr[1] = 5'd7;
      #1 check("dual_same_cycle", bus.read_data[1], BYP ? 64'h22 : 64'd0);
      @(negedge clk) bus.write_enable = '0;
      #1 check("dual_x7_p0", bus.read_data[0], 64'h22);
      check("dual_x7_p1", bus.read_data[1], 64'h22);
      bus.reserve_enable = 1'b1;
      bus.reserve_addr = 5'd3;
      @(negedge clk) bus.reserve_enable = 1'b0;
      bus.read_addr[0] = 5'd3;
      #1 check("rsv_x3_busy", 64'(bus.read_busy[0]), 64'd1);
      check("rsv_x3_vec", 64'(bus.busy_vec), 64'h8);
      bus.write_enable[0] = 1'b1;
      bus.write_addr[0] = 5'd3;
      bus.write_data[0] = 64'h33;
      bus.reserve_enable = 1'b1;
      #1 check("wr_rsv_rbusy", 64'(bus.read_busy[0]), BYP ? 64'd0 : 64'd1);
      @(negedge clk);
      bus.write_enable = '0;
      bus.reserve_enable = 1'b0;
      #1 check("wr_rsv_vec", 64'(bus.busy_vec), 64'h8);
      check("wr_rsv_data", bus.read_data[0], 64'h33);
      bus.write_enable[0] = 1'b1;
      bus.write_data[0] = 64'h34;
      @(negedge clk) bus.write_enable = '0;
      #1 check("wr_clear_vec", 64'(bus.busy_vec), 64'd0);
      check("wr_clear_rbusy", 64'(bus.read_busy[0]), 64'd0);
      check("wr_clear_data", bus.read_data[0], 64'h34);
      bus.reserve_enable = 1'b1;
      foreach (bus.write_addr[i]) bus.write_addr[i] = 5'd0;
      bus.reserve_addr = 5'd3;
      @(negedge clk) bus.reserve_addr = 5'd4;
      @(negedge clk) bus.reserve_addr = 5'd9;
      @(negedge clk) bus.reserve_enable = 1'b0;
      #1 check("rsv_three_vec", 64'(bus.busy_vec), 64'h218);
      bus.flush = 1'b1;
      bus.reserve_enable = 1'b1;
      bus.reserve_addr = 5'd10;
      bus.write_enable[0] = 1'b1;
      bus.write_addr[0] = 5'd9;
      bus.write_data[0] = 64'h99;
      @(negedge clk);
      bus.flush = 1'b0;
      bus.reserve_enable = 1'b0;
      bus.write_enable = '0;
      #1 check("flush_vec", 64'(bus.busy_vec), 64'd0);
      bus.read_addr[0] = 5'd9;
      #1 check("flush_write_x9", bus.read_data[0], 64'h99);
      bus.reserve_enable = 1'b1;
      bus.reserve_addr = 5'd5;
      @(negedge clk) bus.reserve_enable = 1'b0;
      bus.read_addr[0] = 5'd5;
      bus.read_addr[1] = 5'd5;
      bus.read_enable = 2'b01;
      #1 check("ren_on_rd0", bus.read_data[0], BIG);
      check("ren_on_rb0", 64'(bus.read_busy[0]), 64'd1);
      check("ren_off_rd1", bus.read_data[1], 64'd0);
      check("ren_off_rb1", 64'(bus.read_busy[1]), 64'd0);
      bus.read_enable = 2'b10;
      #1 check("ren_off_rd0", bus.read_data[0], 64'd0);
      check("ren_off_rb0", 64'(bus.read_busy[0]), 64'd0);
      check("ren_on_rd1", bus.read_data[1], BIG);
      check("ren_on_rb1", 64'(bus.read_busy[1]), 64'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
